// File: rtl/branch_update_unit.sv
// branch_update_unit: in-order tracker of predicted branches.
// Trains the gshare PHT on resolve and flags mispredicts.
module branch_update_unit #(
  parameter int DEPTH       = 4,
  parameter int INDEX_WIDTH = 8,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [INDEX_WIDTH-1:0] push_index,
  input  logic                   push_prediction,
  output logic                   push_ready,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic                   flush,
  output logic                   update_enable,
  output logic [INDEX_WIDTH-1:0] update_index,
  output logic                   outcome,
  output logic                   mispredict,
  output logic [CNT_W-1:0]       count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INDEX_WIDTH-1:0] idx_q [DEPTH];
  logic                   pred_q [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic res_acc;
  logic mis_now;
  logic push_acc;
  logic squash;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = !full;

  assign res_acc  = resolve_valid && !empty;
  assign mis_now  = res_acc && (resolve_taken != pred_q[head]);
  assign squash   = mis_now || flush;
  assign push_acc = push_valid && !full && !squash;

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      idx_q[tail]  <= push_index;
      pred_q[tail] <= push_prediction;
    end
  end

  // Pointers, occupancy and the registered predictor update port.
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      update_enable <= 1'b0;
      update_index  <= '0;
      outcome       <= 1'b0;
      mispredict    <= 1'b0;
    end else begin
      update_enable <= res_acc;
      mispredict    <= mis_now;
      if (res_acc) begin
        update_index <= idx_q[head];
        outcome      <= resolve_taken;
      end
      if (squash) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_acc) tail <= tail + PTR_W'(1);
        if (res_acc)  head <= head + PTR_W'(1);
        count <= count + CNT_W'(push_acc)
                       - CNT_W'(res_acc);
      end
    end
  end

endmodule

// File: tb/tb_branch_update_unit.sv
// tb_branch_update_unit: random + directed stimulus
// checked against a queue-based reference model.
module tb_branch_update_unit;

  localparam int DEPTH = 4;
  localparam int IW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic [IW-1:0] push_index;
  logic          push_prediction;
  logic          push_ready;
  logic          resolve_valid;
  logic          resolve_taken;
  logic          flush;
  logic          update_enable;
  logic [IW-1:0] update_index;
  logic          outcome;
  logic          mispredict;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  typedef struct {
    logic [IW-1:0] idx;
    logic          pred;
  } ent_t;

  ent_t          q[$];
  logic [IW-1:0] m_idx;
  logic          m_out;

  int total = 0;
  int bad   = 0;

  branch_update_unit #(
    .DEPTH(DEPTH),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_valid(push_valid),
    .push_index(push_index),
    .push_prediction(push_prediction),
    .push_ready(push_ready),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .flush(flush),
    .update_enable(update_enable),
    .update_index(update_index),
    .outcome(outcome),
    .mispredict(mispredict),
    .count(count),
    .empty(empty),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input logic ue,
                             input logic mis);
    chk("count", 32'(count), q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("update_enable", 32'(update_enable), 32'(ue));
    chk("mispredict", 32'(mispredict), 32'(mis));
    chk("update_index", 32'(update_index), 32'(m_idx));
    chk("outcome", 32'(outcome), 32'(m_out));
  endtask

  task automatic step(input logic pv,
                      input logic [IW-1:0] pi,
                      input logic pp,
                      input logic rv,
                      input logic rt,
                      input logic fl);
    int   n;
    logic res;
    logic mis;
    ent_t e;
    push_valid      = pv;
    push_index      = pi;
    push_prediction = pp;
    resolve_valid   = rv;
    resolve_taken   = rt;
    flush           = fl;
    n   = q.size();
    chk("push_ready", 32'(push_ready), 32'(n != DEPTH));
    res = rv && (n > 0);
    mis = 1'b0;
    if (res) begin
      mis   = (rt != q[0].pred);
      m_idx = q[0].idx;
      m_out = rt;
    end
    @(posedge clk);
    #1;
    if (mis || fl) begin
      q.delete();
    end else begin
      if (res) void'(q.pop_front());
      if (pv && n != DEPTH) begin
        e.idx  = pi;
        e.pred = pp;
        q.push_back(e);
      end
    end
    check_state(res, mis);
  endtask

  task automatic push(input logic [IW-1:0] i,
                      input logic p);
    step(1'b1, i, p, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic t);
    step(1'b0, '0, 1'b0, 1'b1, t, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    push_valid      = 1'b1;
    push_index      = 8'hAA;
    push_prediction = 1'b1;
    resolve_valid   = 1'b0;
    resolve_taken   = 1'b0;
    flush           = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    q.delete();
    m_idx = '0;
    m_out = 1'b0;
    chk("rst_ready", 32'(push_ready), 32'd1);
    check_state(1'b0, 1'b0);
    rst = 1'b0;

    // in-order training
    push(8'h3A, 1'b1);
    push(8'h51, 1'b0);
    resolve(1'b1);
    chk("train0_idx", 32'(update_index), 32'h3A);
    resolve(1'b0);
    chk("train1_idx", 32'(update_index), 32'h51);
    idle();

    // mispredict squash with same-cycle push
    push(8'h10, 1'b1);
    push(8'h20, 1'b1);
    push(8'h30, 1'b0);
    step(1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("squash_mis", 32'(mispredict), 32'd1);
    chk("squash_cnt", 32'(count), 32'd0);
    resolve(1'b1);
    chk("empty_res", 32'(update_enable), 32'd0);

    // full and wrap
    push(8'h01, 1'b1);
    push(8'h02, 1'b0);
    push(8'h03, 1'b1);
    push(8'h04, 1'b0);
    push(8'h05, 1'b1);
    chk("full_flag", 32'(full), 32'd1);
    step(1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b0);
    resolve(1'b0);
    push(8'h07, 1'b1);
    push(8'h08, 1'b0);
    resolve(1'b1);
    chk("wrap_idx", 32'(update_index), 32'h03);
    resolve(1'b0);
    resolve(1'b1);
    resolve(1'b0);
    chk("wrap_last", 32'(update_index), 32'h08);

    // simultaneous push/resolve at count 2
    push(8'h11, 1'b1);
    push(8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sim_cnt", 32'(count), 32'd2);
    resolve(1'b0);
    resolve(1'b1);

    // flush with and without resolve
    push(8'h7F, 1'b1);
    push(8'h12, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("fl_idx", 32'(update_index), 32'h7F);
    push(8'h21, 1'b0);
    push(8'h22, 1'b1);
    push(8'h23, 1'b0);
    step(1'b1, 8'h24, 1'b0, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6,
           IW'($urandom),
           1'($urandom),
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
